// File: rtl/arb_pkg.sv
// Shared types and the round-robin pick helper for the 4-source arbiter.
package arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int NUM_REQ = 4;

  // First requester strictly after `from`, wrapping; `from` itself ranks last.
  function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] from);
    logic [1:0] idx;
    logic       found;
    rr_pick = from;
    found   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = from + 2'(k);
      if (!found && v[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mux4.sv
// Plain 4:1 datapath multiplexer of width N.
module mux4 #(
  parameter int N = 32
) (
  input  logic [N-1:0] d0,
  input  logic [N-1:0] d1,
  input  logic [N-1:0] d2,
  input  logic [N-1:0] d3,
  input  logic [1:0]   s,
  output logic [N-1:0] y
);

  always_comb begin
    case (s)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/rr_arb4.sv
// Round-robin arbiter sharing one valid/ready channel between four sources.
// Define ARB4_LOCK_EN to hold the grant across a burst until in_last.
module rr_arb4
  import arb_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   in_valid,
  input  logic [3:0]   in_last,
  input  logic [W-1:0] in_data0,
  input  logic [W-1:0] in_data1,
  input  logic [W-1:0] in_data2,
  input  logic [W-1:0] in_data3,
  output logic [3:0]   in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   sel,
  output logic         busy
);

  arb_state_t state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] last_grant_q, last_grant_d;
  logic       in_grant;
  logic       xfer;
  logic       rotate;
  logic       drop;

`ifdef ARB4_LOCK_EN
  logic locked_q, locked_d;
`else
  logic unused_in_last;
  assign unused_in_last = ^in_last;
`endif

  assign in_grant  = (state_q == GRANT);
  assign busy      = in_grant;
  assign sel       = grant_q;
  // Reset gates the handshake so no beat is accepted in the reset cycle.
  assign out_valid = in_grant && in_valid[grant_q] && !rst;
  assign in_ready  = (in_grant && out_ready && !rst) ? (4'b0001 << grant_q) : 4'b0000;
  assign xfer      = out_valid && out_ready;

  mux4 #(.N(W)) u_mux (
    .d0 (in_data0),
    .d1 (in_data1),
    .d2 (in_data2),
    .d3 (in_data3),
    .s  (grant_q),
    .y  (out_data)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
`ifdef ARB4_LOCK_EN
    locked_d     = locked_q;
    rotate       = xfer && in_last[grant_q];
    drop         = in_grant && !in_valid[grant_q] && !locked_q;
    if (xfer) locked_d = !in_last[grant_q];
`else
    rotate       = xfer;
    drop         = in_grant && !in_valid[grant_q];
`endif

    case (state_q)
      IDLE: begin
        if (in_valid != 4'b0000) begin
          grant_d = rr_pick(in_valid, last_grant_q);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (rotate) begin
          last_grant_d = grant_q;
          if (in_valid != 4'b0000) grant_d = rr_pick(in_valid, grant_q);
          else                     state_d = IDLE;
        end else if (drop) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd3;
`ifdef ARB4_LOCK_EN
      locked_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
`ifdef ARB4_LOCK_EN
      locked_q     <= locked_d;
`endif
    end
  end

endmodule
